ascon_result_collector: RTL and testbench
=========================================

Name: ascon_result_collector

Overview:
- Sits directly downstream of the SoC encryption wrapper's byte-serial result port.
- On each encryption completion, issues a one-cycle readout request, captures the ciphertext bytes and then the tag bytes at fixed cycle offsets, and buffers them.
- Re-emits the buffered bytes on a valid/ready byte stream to the host or UART bridge, with backpressure, a last flag and a ciphertext/tag marker.

Parameters:
- Y, 32, ciphertext length in bits; multiple of 8, at least 8.
- T, 128, tag length in bits; multiple of 8.
- LEAD, 2, cycles from the rd_req_o pulse to the first valid ciphertext byte on res_byte_i; at least 1.
- GAP, 1, junk cycles between the last ciphertext byte and the first tag byte; 0 allowed.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, synchronous, active-low.
- enc_ready_i, input, 1, level from the wrapper: encryption result valid.
- rd_req_o, output, 1, one-cycle readout request; drives the wrapper's output-select strobe.
- res_byte_i, input, 8, wrapper result byte stream.
- m_data_o, output, 8, buffered output byte.
- m_valid_o, output, 1, m_data_o valid.
- m_ready_i, input, 1, consumer accepts the byte.
- m_last_o, output, 1, high with the final tag byte.
- m_is_tag_o, output, 1, current byte belongs to the tag.
- busy_o, output, 1, high in any state other than IDLE.
- err_o, output, 1, sticky abort flag.

Behaviour:
- Reset: rst=0 at a clk edge forces IDLE; clears counters and buffer. Outputs after reset: rd_req_o=0, m_valid_o=0, m_last_o=0, m_is_tag_o=0, m_data_o=0, busy_o=0, err_o=0. Reset mid-operation discards captured data; no partial drain.
- Buffer: NB = Y/8 + T/8 bytes; index 0 holds the first captured byte, which is the ciphertext MSB.
- Rearm: rearm flag is set in reset and whenever enc_ready_i=0 is sampled.
- States:
  - IDLE: if enc_ready_i=1 and rearm=1: rd_req_o=1 for exactly this cycle, clear err_o, clear rearm, load cnt=LEAD-1, go to LEAD.
  - LEAD: decrement cnt; at cnt=0 go to CAP_CT with idx=0. The first capture therefore occurs LEAD cycles after the rd_req_o cycle.
  - CAP_CT: buf[idx] <= res_byte_i each cycle, idx+1. After Y/8 captures go to SKIP if GAP>0, else CAP_TAG.
  - SKIP: ignore res_byte_i for GAP cycles, then go to CAP_TAG.
  - CAP_TAG: capture T/8 bytes into buf[Y/8 ..], then go to DRAIN with rd=0.
  - DRAIN: m_valid_o=1 and m_data_o=buf[rd], both registered (stable while stalled).
    - m_is_tag_o = (rd >= Y/8).
    - m_last_o = (rd = NB-1).
    - On m_valid_o && m_ready_i: rd+1. When the last byte is accepted, drop m_valid_o the next cycle and go to IDLE.
  - Held m_ready_i=0: data, valid and flags stay unchanged indefinitely. AXI-style rule: valid never drops without a handshake.
- Abort: enc_ready_i=0 sampled during LEAD, CAP_CT, SKIP or CAP_TAG sets err_o=1 and returns to IDLE with no drain. enc_ready_i dropping during DRAIN has no effect.
- No re-trigger: a new request needs enc_ready_i to be low for at least 1 cycle and then high, and the FSM must be in IDLE. enc_ready_i held high after a drain does not re-trigger.
- Simultaneous events: enc_ready_i rising in the same cycle the last byte is accepted is ignored until IDLE is sampled (one-cycle IDLE minimum).
- Counter widths: clog2(NB)+1; no wrap, since terminal counts are explicit.
- Latency, request to first m_valid_o, for LEAD=2, GAP=1, Y=32, T=128: 2 + 4 + 1 + 16 = 23 cycles.

Decomposition:
- Shared package:
  - state enum (IDLE, LEAD, CAP_CT, SKIP, CAP_TAG, DRAIN);
  - byte-count constants CT_BYTES = Y/8, TAG_BYTES = T/8, NB;
  - default LEAD and GAP values, shared with the wrapper.
- One sub-module: ascon_byte_buffer. NB x 8 register file with a write port (idx, data, we) and a registered read port (rd) feeding m_data_o.
- FSM and counters stay in the top module.

Test Plan:
- Nominal: model drives ciphertext 0xDEADBEEF then tag 0x00112233445566778899AABBCCDDEEFF at the LEAD/GAP offsets, m_ready_i=1 -> rd_req_o pulses once. Stream is DE AD BE EF 00 11 .. FF; m_is_tag_o rises at byte 4; m_last_o is high only on FF; first m_valid_o 23 cycles after rd_req_o.
- Backpressure: m_ready_i low for 5 cycles at byte 2 and toggled 1/0 thereafter -> byte BE held stable with valid high; no byte dropped or duplicated; total 20 handshakes.
- Abort: enc_ready_i drops on the 3rd CAP_CT cycle -> err_o=1, no m_valid_o. The next enc_ready_i rise clears err_o and a full correct stream follows.
- Rearm: enc_ready_i held high across two drain completions -> exactly one rd_req_o. A low pulse of 1 cycle then high -> second rd_req_o.
- Reset mid-DRAIN: rst=0 at byte 7 -> the next cycle shows m_valid_o=0, busy_o=0, err_o=0, and no residual bytes after release.
- Parameter sweep Y=8, GAP=0, LEAD=1 -> single ciphertext byte, tag captured on the immediately following cycle, stream of 17 bytes.

Source files
------------

// File: rtl/ascon_result_collector_pkg.sv
// Shared types and default geometry for the ASCON result collector and its wrapper.
package ascon_result_collector_pkg;

  localparam int DEF_Y    = 32;
  localparam int DEF_T    = 128;
  localparam int DEF_LEAD = 2;
  localparam int DEF_GAP  = 1;

  localparam int CT_BYTES  = DEF_Y / 8;
  localparam int TAG_BYTES = DEF_T / 8;
  localparam int NB        = CT_BYTES + TAG_BYTES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_CAP_CT,
    S_SKIP,
    S_CAP_TAG,
    S_DRAIN
  } state_e;

  function automatic int nb_bytes(input int y, input int t);
    return (y / 8) + (t / 8);
  endfunction

endpackage

// File: rtl/ascon_result_collector_byte.sv
// NB x 8 capture buffer: one write port, one registered read port feeding the output byte.
module ascon_byte_buffer
  import ascon_result_collector_pkg::*;
#(
  parameter int unsigned NBYTES = NB,
  parameter int unsigned AW     = $clog2(NB)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [NBYTES];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ascon_result_collector.sv
// Captures ciphertext and tag bytes from the wrapper's serial result port after each
// completion and replays them on a valid/ready byte stream with last/tag markers.
module ascon_result_collector
  import ascon_result_collector_pkg::*;
#(
  parameter int Y    = DEF_Y,
  parameter int T    = DEF_T,
  parameter int LEAD = DEF_LEAD,
  parameter int GAP  = DEF_GAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_ready_i,
  output logic       rd_req_o,
  input  logic [7:0] res_byte_i,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic       m_last_o,
  output logic       m_is_tag_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int CTB    = Y / 8;
  localparam int NBYTES = nb_bytes(Y, T);
  localparam int CW     = $clog2(NBYTES) + 1;
  localparam int AW     = $clog2(NBYTES);
  localparam int DW     = $clog2(LEAD + GAP + 1) + 1;

  state_e        state_q;
  logic [CW-1:0] idx_q;
  logic [CW-1:0] rd_q;
  logic [DW-1:0] cnt_q;
  logic          rd_req_q;
  logic          m_valid_q;
  logic          m_last_q;
  logic          m_is_tag_q;
  logic          err_q;
  logic          rearm_q;

  logic          hs;
  logic          ct_done;
  logic          tag_done;
  logic          rd_last;
  logic          cap_we;
  logic          rd_load;
  logic [CW-1:0] rd_nxt;
  logic [AW-1:0] rd_addr;

  // The read port is registered, so it is addressed with the index the drain will
  // present next cycle: byte 0 on the final tag capture, rd+1 on each accepted handshake.
  always_comb begin
    hs       = m_valid_q && m_ready_i;
    ct_done  = (idx_q == CW'(CTB - 1));
    tag_done = (idx_q == CW'(NBYTES - 1));
    rd_last  = (rd_q == CW'(NBYTES - 1));
    rd_nxt   = rd_q + CW'(1);
    cap_we   = enc_ready_i && ((state_q == S_CAP_CT) || (state_q == S_CAP_TAG));
    rd_load  = 1'b0;
    rd_addr  = '0;
    if ((state_q == S_CAP_TAG) && enc_ready_i && tag_done) begin
      rd_load = 1'b1;
    end else if ((state_q == S_DRAIN) && hs && !rd_last) begin
      rd_load = 1'b1;
      rd_addr = rd_nxt[AW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      rd_req_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_is_tag_q <= 1'b0;
      err_q      <= 1'b0;
      rearm_q    <= 1'b1;
    end else begin
      rd_req_q <= 1'b0;
      if (!enc_ready_i) begin
        rearm_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (enc_ready_i && rearm_q) begin
            rd_req_q <= 1'b1;
            err_q    <= 1'b0;
            rearm_q  <= 1'b0;
            cnt_q    <= DW'(LEAD - 1);
            state_q  <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (!enc_ready_i) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            idx_q   <= '0;
            state_q <= S_CAP_CT;
          end else begin
            cnt_q <= cnt_q - DW'(1);
          end
        end
        S_CAP_CT: begin
          if (!enc_ready_i) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            idx_q <= idx_q + CW'(1);
            if (ct_done) begin
              if (GAP > 0) begin
                cnt_q   <= DW'(GAP - 1);
                state_q <= S_SKIP;
              end else begin
                state_q <= S_CAP_TAG;
              end
            end
          end
        end
        S_SKIP: begin
          if (!enc_ready_i) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= S_CAP_TAG;
          end else begin
            cnt_q <= cnt_q - DW'(1);
          end
        end
        S_CAP_TAG: begin
          if (!enc_ready_i) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (tag_done) begin
            // Byte 0 is always ciphertext and never last, since both fields are non-empty.
            rd_q       <= '0;
            m_valid_q  <= 1'b1;
            m_is_tag_q <= 1'b0;
            m_last_q   <= 1'b0;
            state_q    <= S_DRAIN;
          end else begin
            idx_q <= idx_q + CW'(1);
          end
        end
        S_DRAIN: begin
          if (hs) begin
            if (rd_last) begin
              m_valid_q  <= 1'b0;
              m_last_q   <= 1'b0;
              m_is_tag_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              rd_q       <= rd_nxt;
              m_is_tag_q <= (rd_nxt >= CW'(CTB));
              m_last_q   <= (rd_nxt == CW'(NBYTES - 1));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  ascon_byte_buffer #(
    .NBYTES(NBYTES),
    .AW    (AW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .we_i   (cap_we),
    .waddr_i(idx_q[AW-1:0]),
    .wdata_i(res_byte_i),
    .re_i   (rd_load),
    .raddr_i(rd_addr),
    .rdata_o(m_data_o)
  );

  assign rd_req_o   = rd_req_q;
  assign m_valid_o  = m_valid_q;
  assign m_last_o   = m_last_q;
  assign m_is_tag_o = m_is_tag_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ascon_result_collector.sv
// Self-checking bench: wrapper byte-port model feeding two collector configurations.
module tb_ascon_result_collector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] enc_ready;
  logic [1:0] rd_req;
  logic [1:0][7:0] res_byte;
  logic [1:0][7:0] m_data;
  logic [1:0] m_valid;
  logic [1:0] m_ready;
  logic [1:0] m_last;
  logic [1:0] m_is_tag;
  logic [1:0] busy;
  logic [1:0] err;

  int checks = 0;
  int failures = 0;

  logic [7:0] ct_b  [2][4];
  logic [7:0] tag_b [2][16];
  logic [7:0] q_data[$];
  bit         q_tag [$];
  bit         q_last[$];
  int         tt [2] = '{1000, 1000};

  always #5 clk = ~clk;

  ascon_result_collector #(.Y(32), .T(128), .LEAD(2), .GAP(1)) dut0 (
    .clk(clk), .rst(rst), .enc_ready_i(enc_ready[0]), .rd_req_o(rd_req[0]),
    .res_byte_i(res_byte[0]), .m_data_o(m_data[0]), .m_valid_o(m_valid[0]),
    .m_ready_i(m_ready[0]), .m_last_o(m_last[0]), .m_is_tag_o(m_is_tag[0]),
    .busy_o(busy[0]), .err_o(err[0])
  );

  ascon_result_collector #(.Y(8), .T(128), .LEAD(1), .GAP(0)) dut1 (
    .clk(clk), .rst(rst), .enc_ready_i(enc_ready[1]), .rd_req_o(rd_req[1]),
    .res_byte_i(res_byte[1]), .m_data_o(m_data[1]), .m_valid_o(m_valid[1]),
    .m_ready_i(m_ready[1]), .m_last_o(m_last[1]), .m_is_tag_o(m_is_tag[1]),
    .busy_o(busy[1]), .err_o(err[1])
  );

  function automatic int ctb_of(input int s);  return (s == 0) ? 4 : 1; endfunction
  function automatic int lead_of(input int s); return (s == 0) ? 2 : 1; endfunction
  function automatic int gap_of(input int s);  return (s == 0) ? 1 : 0; endfunction
  function automatic int nb_of(input int s);   return ctb_of(s) + 16; endfunction

  // Wrapper model: cycle t counts from the rd_req cycle (t=0); bytes outside the
  // ciphertext/tag windows are random junk.
  function automatic logic [7:0] wire_byte(input int s, input int t);
    int c0 = lead_of(s);
    int g0 = c0 + ctb_of(s) + gap_of(s);
    if (t >= c0 && t < c0 + ctb_of(s)) return ct_b[s][t-c0];
    if (t >= g0 && t < g0 + 16) return tag_b[s][t-g0];
    return 8'($urandom);
  endfunction

  function automatic logic [7:0] exp_byte(input int s, input int i);
    if (i < ctb_of(s)) return ct_b[s][i];
    return tag_b[s][i-ctb_of(s)];
  endfunction

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rd_req[s]) tt[s] = 0;
      else if (tt[s] < 1000) tt[s] = tt[s] + 1;
      res_byte[s] = wire_byte(s, tt[s]);
    end
  end

  task automatic load_data(input int s, input bit fixed);
    for (int i = 0; i < 4; i++) ct_b[s][i] = fixed ? 8'(32'hDEADBEEF >> (24 - 8*i)) : 8'($urandom);
    for (int j = 0; j < 16; j++) tag_b[s][j] = fixed ? 8'(j * 17) : 8'($urandom);
  endtask

  task automatic pulse_low(input int s);
    @(negedge clk); enc_ready[s] = 1'b0;
    @(negedge clk); enc_ready[s] = 1'b1;
  endtask

  // Consumer: records handshakes; mode 1 stalls 5 cycles on byte 2 then toggles ready.
  task automatic run_txn(input int s, input int mode, input int stop_at,
                         output int lat, output int unstable, output int nreq, output bit done);
    int n = 0, t0 = 0, stalls = 0;
    bit tog = 1'b1, seen_valid = 1'b0, prev_stall = 1'b0;
    logic [7:0] pd = '0;
    logic pt = 1'b0, pl = 1'b0;
    q_data.delete(); q_tag.delete(); q_last.delete();
    lat = -1; unstable = 0; nreq = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      if (rd_req[s]) begin nreq++; t0 = cyc; end
      if (m_valid[s] && !seen_valid) begin seen_valid = 1'b1; lat = cyc - t0; end
      if (prev_stall && (!m_valid[s] || m_data[s] !== pd || m_is_tag[s] !== pt || m_last[s] !== pl))
        unstable++;
      if (stop_at >= 0 && n == stop_at && m_valid[s]) return;
      if (mode == 1 && n == 2 && stalls < 5) begin m_ready[s] = 1'b0; stalls++; end
      else if (mode == 1 && stalls == 5) begin m_ready[s] = tog; tog = !tog; end
      else m_ready[s] = 1'b1;
      prev_stall = m_valid[s] && !m_ready[s];
      pd = m_data[s]; pt = m_is_tag[s]; pl = m_last[s];
      if (m_valid[s] && m_ready[s]) begin
        q_data.push_back(m_data[s]); q_tag.push_back(m_is_tag[s]); q_last.push_back(m_last[s]);
        n++;
        if (m_last[s]) done = 1'b1;
      end
    end
    m_ready[s] = 1'b1;
  endtask

  task automatic test_reset();
    logic [13:0] v;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      v = {rd_req[s], m_valid[s], m_last[s], m_is_tag[s], busy[s], err[s], m_data[s]};
      checks++;
      if (v !== 14'h0) begin failures++; $display("FAIL reset_held[%0d] got=%h exp=0", s, v); end
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      v = {rd_req[s], m_valid[s], m_last[s], m_is_tag[s], busy[s], err[s], m_data[s]};
      checks++;
      if (v !== 14'h0) begin failures++; $display("FAIL reset_released[%0d] got=%h exp=0", s, v); end
    end
  endtask

  task automatic test_nominal();
    int lat, unst, nreq; bit done;
    load_data(0, 1'b1);
    @(negedge clk); enc_ready[0] = 1'b1;
    run_txn(0, 0, -1, lat, unst, nreq, done);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL nominal_done got=%0b exp=1", done); end
    checks++; if (nreq != 1) begin failures++; $display("FAIL nominal_rdreq got=%0d exp=1", nreq); end
    checks++; if (lat != 23) begin failures++; $display("FAIL nominal_latency got=%0d exp=23", lat); end
    checks++; if (q_data.size() != 20) begin failures++; $display("FAIL nominal_len got=%0d exp=20", q_data.size()); end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_byte(0, i) || q_tag[i] !== (i >= 4) || q_last[i] !== (i == 19)) begin
        failures++;
        $display("FAIL nominal_byte[%0d] got d=%h t=%0b l=%0b exp d=%h t=%0b l=%0b",
                 i, q_data[i], q_tag[i], q_last[i], exp_byte(0, i), i >= 4, i == 19);
      end
    end
    @(negedge clk);
    checks++;
    if ({m_valid[0], m_last[0], busy[0]} !== 3'b000) begin
      failures++; $display("FAIL nominal_after got v/l/busy=%b exp=000", {m_valid[0], m_last[0], busy[0]});
    end
  endtask

  task automatic test_rearm();
    int lat, unst, nreq, extra; bit done;
    extra = 0;
    repeat (30) begin @(negedge clk); if (rd_req[0] || m_valid[0]) extra++; end
    checks++; if (extra != 0) begin failures++; $display("FAIL rearm_held_high got=%0d exp=0", extra); end
    load_data(0, 1'b0);
    pulse_low(0);
    run_txn(0, 0, -1, lat, unst, nreq, done);
    checks++; if (nreq != 1 || lat != 23) begin failures++; $display("FAIL rearm_req got req=%0d lat=%0d exp req=1 lat=23", nreq, lat); end
    checks++; if (q_data.size() != 20 || !done) begin failures++; $display("FAIL rearm_len got=%0d exp=20", q_data.size()); end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_byte(0, i)) begin
        failures++; $display("FAIL rearm_byte[%0d] got=%h exp=%h", i, q_data[i], exp_byte(0, i));
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, unst, nreq; bit done;
    load_data(0, 1'b1);
    pulse_low(0);
    run_txn(0, 1, -1, lat, unst, nreq, done);
    checks++; if (unst != 0) begin failures++; $display("FAIL bp_stable got=%0d changes exp=0", unst); end
    checks++; if (q_data.size() != 20 || !done) begin failures++; $display("FAIL bp_handshakes got=%0d exp=20", q_data.size()); end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_byte(0, i) || q_tag[i] !== (i >= 4) || q_last[i] !== (i == 19)) begin
        failures++;
        $display("FAIL bp_byte[%0d] got d=%h t=%0b l=%0b exp d=%h t=%0b l=%0b",
                 i, q_data[i], q_tag[i], q_last[i], exp_byte(0, i), i >= 4, i == 19);
      end
    end
  endtask

  task automatic test_abort();
    int lat, unst, nreq, bad; bit done, got;
    got = 1'b0; bad = 0;
    load_data(0, 1'b0);
    pulse_low(0);
    for (int k = 0; k < 10 && !got; k++) begin @(negedge clk); got = rd_req[0]; end
    checks++; if (!got) begin failures++; $display("FAIL abort_req got=0 exp=1"); end
    repeat (4) @(negedge clk);
    enc_ready[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({err[0], busy[0]} !== 2'b10) begin failures++; $display("FAIL abort_err got err/busy=%b exp=10", {err[0], busy[0]}); end
    repeat (30) begin @(negedge clk); if (m_valid[0] || !err[0]) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL abort_quiet got=%0d bad cycles exp=0", bad); end
    load_data(0, 1'b0);
    enc_ready[0] = 1'b1;
    run_txn(0, 0, -1, lat, unst, nreq, done);
    checks++; if (err[0] !== 1'b0) begin failures++; $display("FAIL abort_err_clear got=%0b exp=0", err[0]); end
    checks++; if (q_data.size() != 20 || lat != 23) begin failures++; $display("FAIL abort_retry got len=%0d lat=%0d exp 20/23", q_data.size(), lat); end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_byte(0, i)) begin
        failures++; $display("FAIL abort_byte[%0d] got=%h exp=%h", i, q_data[i], exp_byte(0, i));
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int lat, unst, nreq, bad; bit done;
    bad = 0;
    load_data(0, 1'b0);
    pulse_low(0);
    run_txn(0, 0, 7, lat, unst, nreq, done);
    checks++; if (q_data.size() != 7 || done) begin failures++; $display("FAIL rstd_progress got=%0d exp=7", q_data.size()); end
    rst = 1'b0; enc_ready[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_valid[0], busy[0], err[0], m_data[0]} !== 11'h0) begin
      failures++; $display("FAIL rstd_clear got v/b/e/d=%b exp=0", {m_valid[0], busy[0], err[0], m_data[0]});
    end
    rst = 1'b1;
    repeat (40) begin @(negedge clk); if (m_valid[0] || rd_req[0]) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL rstd_residual got=%0d exp=0", bad); end
  endtask

  task automatic test_sweep();
    int lat, unst, nreq; bit done;
    load_data(1, 1'b0);
    @(negedge clk); enc_ready[1] = 1'b1;
    run_txn(1, 0, -1, lat, unst, nreq, done);
    checks++; if (nreq != 1 || lat != 18) begin failures++; $display("FAIL sweep_req got req=%0d lat=%0d exp 1/18", nreq, lat); end
    checks++; if (q_data.size() != 17 || !done) begin failures++; $display("FAIL sweep_len got=%0d exp=17", q_data.size()); end
    for (int i = 0; i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== exp_byte(1, i) || q_tag[i] !== (i >= 1) || q_last[i] !== (i == 16)) begin
        failures++;
        $display("FAIL sweep_byte[%0d] got d=%h t=%0b l=%0b exp d=%h t=%0b l=%0b",
                 i, q_data[i], q_tag[i], q_last[i], exp_byte(1, i), i >= 1, i == 16);
      end
    end
    @(negedge clk);
    checks++; if (m_valid[1] !== 1'b0) begin failures++; $display("FAIL sweep_after got=%0b exp=0", m_valid[1]); end
  endtask

  initial begin
    enc_ready = '0;
    m_ready   = '1;
    res_byte  = '0;
    load_data(0, 1'b1);
    load_data(1, 1'b0);
    test_reset();
    test_nominal();
    test_rearm();
    test_backpressure();
    test_abort();
    test_reset_mid_drain();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
